// File: rtl/fixed_point_div_dispatch.sv
// fixed_point_div_dispatch
// Queues signed Q(QM).(QN) divide requests, issues them one at a time to an
// external divider, guards each with a watchdog and holds the result in a
// single output slot until the consumer takes it. Operands and quotients pass
// through untouched; this block never does arithmetic on them.
//
// Handshake semantics (both in_* and out_* ports): a transfer happens on a
// rising clock edge where valid && ready are both 1. A producer holding valid
// keeps its payload stable until the transfer. in_ready depends only on the
// queue fill level and reset, never on in_valid or a same-cycle pop.
// out_valid/out_* are registered and stay stable until out_ready is seen.
// div_valid is a one-cycle start pulse; the divider answers with a one-cycle
// div_done, which is only honoured while a request is in flight.
module fixed_point_div_dispatch #(
  parameter int QM         = 12,
  parameter int QN         = 20,
  parameter int DATA_WIDTH = QM + QN,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_numerator,
  input  logic [DATA_WIDTH-1:0]    in_denominator,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     div_valid,
  output logic [DATA_WIDTH-1:0]    div_numerator,
  output logic [DATA_WIDTH-1:0]    div_denominator,
  input  logic                     div_done,
  input  logic [DATA_WIDTH-1:0]    div_quotient,
  input  logic                     div_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_quotient,
  output logic                     out_error,
  output logic                     out_timeout,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  // Last WAIT cycle before expiry: the counter starts at 0 in the first WAIT
  // cycle, so the TIMEOUT-th WAIT cycle sees TIMEOUT-1.
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state;

  logic [DATA_WIDTH-1:0]   num_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   den_mem [DEPTH];
  logic [TAG_WIDTH-1:0]    tag_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;

  logic [TAG_WIDTH-1:0]    flight_tag;
  logic [WD_W-1:0]         wd_cnt;

  logic                    push;
  logic                    pop;
  logic                    slot_free;
  logic                    out_fire;

  // Queue acceptance and issue decision. A full queue refuses a push even if
  // the head is leaving in the same cycle.
  assign in_ready  = !rst && (count < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  // The head leaves the queue on the edge that enters ISSUE, so occupancy
  // never includes the request in flight.
  assign pop       = (state == S_IDLE) && (count != '0) && slot_free;

  assign occupancy = count;
  assign state_dbg = state;

  // Queue storage: written on push, no reset needed because entries are only
  // read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      num_mem[wr_ptr] <= in_numerator;
      den_mem[wr_ptr] <= in_denominator;
      tag_mem[wr_ptr] <= in_tag;
    end
  end

  // Queue pointers and fill count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dispatch FSM with the divider operand registers, watchdog and the
  // registered output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      div_valid       <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      flight_tag      <= '0;
      wd_cnt          <= '0;
      out_valid       <= 1'b0;
      out_quotient    <= '0;
      out_error       <= 1'b0;
      out_timeout     <= 1'b0;
      out_tag         <= '0;
    end else begin
      div_valid <= 1'b0;
      // Draining clears the slot; a reload below in the same cycle wins.
      if (out_fire) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pop) begin
            state           <= S_ISSUE;
            div_valid       <= 1'b1;
            div_numerator   <= num_mem[rd_ptr];
            div_denominator <= den_mem[rd_ptr];
            flight_tag      <= tag_mem[rd_ptr];
          end
        end

        S_ISSUE: begin
          state  <= S_WAIT;
          wd_cnt <= '0;
        end

        S_WAIT: begin
          if (div_done) begin
            // A divider answer in the expiry cycle still counts as normal.
            state        <= S_IDLE;
            out_valid    <= 1'b1;
            out_quotient <= div_quotient;
            out_error    <= div_error;
            out_timeout  <= 1'b0;
            out_tag      <= flight_tag;
          end else if (wd_cnt == WD_LAST) begin
            state        <= S_IDLE;
            out_valid    <= 1'b1;
            out_quotient <= '0;
            out_error    <= 1'b1;
            out_timeout  <= 1'b1;
            out_tag      <= flight_tag;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_div_dispatch.sv
// Bench for fixed_point_div_dispatch: behavioural divider stub, random
// consumer back-pressure and a request/result scoreboard.
module tb_fixed_point_div_dispatch;

  localparam int QM      = 12;
  localparam int QN      = 20;
  localparam int DW      = QM + QN;
  localparam int DEPTH   = 4;
  localparam int TW      = 4;
  localparam int TIMEOUT = 64;
  localparam int REQ_W   = 2 * DW + TW;
  localparam int RES_W   = TW + 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_numerator;
  logic [DW-1:0]         in_denominator;
  logic [TW-1:0]         in_tag;
  logic                  div_valid;
  logic [DW-1:0]         div_numerator;
  logic [DW-1:0]         div_denominator;
  logic                  div_done;
  logic [DW-1:0]         div_quotient;
  logic                  div_error;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_quotient;
  logic                  out_error;
  logic                  out_timeout;
  logic [TW-1:0]         out_tag;
  logic [$clog2(DEPTH):0] occupancy;
  logic [1:0]            state_dbg;

  fixed_point_div_dispatch #(
    .QM(QM), .QN(QN), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .TAG_WIDTH(TW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_numerator(in_numerator), .in_denominator(in_denominator), .in_tag(in_tag),
    .div_valid(div_valid), .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_done(div_done), .div_quotient(div_quotient), .div_error(div_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_error(out_error), .out_timeout(out_timeout),
    .out_tag(out_tag), .occupancy(occupancy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [REQ_W-1:0] req_q[$];
  logic [RES_W-1:0] exp_q[$];
  int  n_push = 0, n_issue = 0, n_out = 0, cyc = 0;
  bit  in_flight = 0, fl_to = 0, prev_ov = 0;
  int  issue_cyc = 0, fl_lat = 0;
  logic [DW-1:0] fl_num, fl_den;
  logic [DW-1:0] last_q;
  logic          last_err, last_to;
  logic [TW-1:0] last_tag;

  int stub_lat = 0;     // 0: random 1..8, -1: never answers, >0: fixed
  int cur_lat = 0;
  int stub_cnt = 0;
  logic [DW-1:0] stub_num, stub_den;
  int ready_mode = 0;   // 0: always ready, 1: never, 2: random
  bit pusher_done = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Signed Q(QM).(QN) quotient: (n / d) scaled by 2^QN, truncated toward zero.
  function automatic logic [DW-1:0] ref_div(input logic [DW-1:0] n, input logic [DW-1:0] d);
    longint nn, dd, q;
    nn = longint'($signed(n));
    dd = longint'($signed(d));
    if (dd == 0) return '0;
    q = (nn * (longint'(1) << QN)) / dd;
    return q[DW-1:0];
  endfunction

  // ---------------- divider stub ----------------
  initial begin : divider_stub
    div_done = 1'b0;
    div_quotient = '0;
    div_error = 1'b0;
    forever begin
      @(posedge clk); #1;
      div_done     = 1'b0;
      div_quotient = $urandom;          // junk outside done cycles
      div_error    = 1'($urandom_range(1, 0));
      if (div_valid) begin
        cur_lat  = (stub_lat == 0) ? int'($urandom_range(8, 1)) : stub_lat;
        stub_num = div_numerator;
        stub_den = div_denominator;
        stub_cnt = cur_lat;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          div_done     = 1'b1;
          div_quotient = ref_div(stub_num, stub_den);
          div_error    = (stub_den == '0);
        end
      end
    end
  end

  // ---------------- consumer ----------------
  initial begin : consumer
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin : monitor
    logic [REQ_W-1:0] r;
    logic [RES_W-1:0] e;
    logic [DW-1:0]    eq;
    bit               eerr;
    cyc++;
    if (rst) begin
      req_q.delete();
      exp_q.delete();
      n_push = 0;
      n_issue = 0;
      in_flight = 0;
      prev_ov = 0;
    end else begin
      if (div_valid) begin
        check_eq("div_valid_while_busy", 64'(in_flight), 64'd0);
        n_issue++;
        if (req_q.size() == 0) begin
          check_eq("issue_without_request", 64'd1, 64'd0);
        end else begin
          r = req_q.pop_front();
          fl_num = r[REQ_W-1 -: DW];
          fl_den = r[TW +: DW];
          check_eq("div_numerator", div_numerator, fl_num);
          check_eq("div_denominator", div_denominator, fl_den);
          fl_lat = cur_lat;
          fl_to  = (cur_lat < 0) || (cur_lat > TIMEOUT);
          eq   = fl_to ? '0 : ref_div(fl_num, fl_den);
          eerr = fl_to || (fl_den == '0);
          e = {r[TW-1:0], fl_to, eerr, eq};
          exp_q.push_back(e);
        end
        in_flight = 1;
        issue_cyc = cyc;
      end
      if (out_valid && !prev_ov) begin
        if (!in_flight) begin
          check_eq("spurious_result", 64'd1, 64'd0);
        end else begin
          check_eq("result_latency", 64'(cyc - issue_cyc), 64'(fl_to ? TIMEOUT + 1 : fl_lat + 1));
          in_flight = 0;
        end
      end
      if (in_flight && !div_valid) begin
        check_eq("div_numerator_hold", div_numerator, fl_num);
        check_eq("div_denominator_hold", div_denominator, fl_den);
      end
      check_eq("occupancy", 64'(occupancy), 64'(n_push - n_issue));
      check_eq("in_ready", 64'(in_ready), 64'((n_push - n_issue) < DEPTH));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_quotient", out_quotient, e[DW-1:0]);
          check_eq("out_error", 64'(out_error), 64'(e[DW]));
          check_eq("out_timeout", 64'(out_timeout), 64'(e[DW+1]));
          check_eq("out_tag", 64'(out_tag), 64'(e[DW+2 +: TW]));
          last_q = out_quotient;
          last_err = out_error;
          last_to = out_timeout;
          last_tag = out_tag;
        end
      end
      if (in_valid && in_ready) begin
        req_q.push_back({in_numerator, in_denominator, in_tag});
        n_push++;
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic push_req(input logic [DW-1:0] n, input logic [DW-1:0] d, input logic [TW-1:0] t);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_numerator = n;
    in_denominator = d;
    in_tag = t;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      ok = in_ready;
      sync();
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) check_eq("push_accepted", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (req_q.size() == 0 && exp_q.size() == 0 && !in_flight && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check_eq("drain_complete", 64'(ok), 64'd1);
    sync();
  endtask

  task automatic check_reset_outputs(input string ctx);
    check_eq({ctx, "_occupancy"}, 64'(occupancy), 64'd0);
    check_eq({ctx, "_div_valid"}, 64'(div_valid), 64'd0);
    check_eq({ctx, "_div_numerator"}, div_numerator, 64'd0);
    check_eq({ctx, "_div_denominator"}, div_denominator, 64'd0);
    check_eq({ctx, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({ctx, "_out_quotient"}, out_quotient, 64'd0);
    check_eq({ctx, "_out_error"}, 64'(out_error), 64'd0);
    check_eq({ctx, "_out_timeout"}, 64'(out_timeout), 64'd0);
    check_eq({ctx, "_out_tag"}, 64'(out_tag), 64'd0);
  endtask

  // ---------------- global bound ----------------
  initial begin
    #2ms;
    $display("FAIL global_time_limit reached t=%0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base_issue, base_out, diff;
    logic [DW-1:0] n, d;

    rst = 1'b1;
    in_valid = 1'b0;
    in_numerator = '0;
    in_denominator = '0;
    in_tag = '0;

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_reset_outputs("rst");
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    sync();

    // 2.5 / 1.5 with a real divider model.
    base_issue = n_issue;
    push_req(32'h0028_0000, 32'h0018_0000, 4'd3);
    wait_idle();
    check_eq("single_issue_pulse", 64'(n_issue - base_issue), 64'd1);
    diff = int'($signed(last_q)) - int'(32'h001A_AAAA);
    check_eq("q_2p5_div_1p5_within_10lsb", 64'(diff >= -10 && diff <= 10), 64'd1);
    check_eq("q_2p5_err", 64'(last_err), 64'd0);
    check_eq("q_2p5_tag", 64'(last_tag), 64'd3);

    // 1.0 / 0.0: divider error, not a timeout.
    push_req(32'h0010_0000, 32'h0000_0000, 4'd5);
    wait_idle();
    check_eq("div0_err", 64'(last_err), 64'd1);
    check_eq("div0_timeout", 64'(last_to), 64'd0);
    check_eq("div0_quotient", last_q, 64'd0);

    // Back-pressure: six back-to-back requests with the consumer stalled.
    ready_mode = 1;
    stub_lat = 2;
    base_out = n_out;
    pusher_done = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) push_req($urandom, $urandom_range(32'h00FF_FFFF, 1), TW'(i));
        pusher_done = 1;
      end
    join_none
    repeat (25) sync();
    @(negedge clk);
    check_eq("stall_occupancy_full", 64'(occupancy), 64'(DEPTH));
    check_eq("stall_in_ready_low", 64'(in_ready), 64'd0);
    check_eq("stall_out_valid", 64'(out_valid), 64'd1);
    check_eq("stall_out_tag_first", 64'(out_tag), 64'd0);
    sync();
    ready_mode = 0;
    for (int k = 0; k < 400 && !pusher_done; k++) sync();
    check_eq("stall_pusher_done", 64'(pusher_done), 64'd1);
    wait_idle();
    check_eq("stall_result_count", 64'(n_out - base_out), 64'd6);
    check_eq("stall_last_tag", 64'(last_tag), 64'd5);

    // Divider never answers: watchdog result, then normal service resumes.
    stub_lat = -1;
    push_req(32'h0030_0000, 32'h0010_0000, 4'd7);
    wait_idle();
    check_eq("wd_err", 64'(last_err), 64'd1);
    check_eq("wd_timeout", 64'(last_to), 64'd1);
    check_eq("wd_quotient", last_q, 64'd0);
    check_eq("wd_tag", 64'(last_tag), 64'd7);
    stub_lat = 0;
    push_req(32'h0030_0000, 32'h0010_0000, 4'd8);
    wait_idle();
    check_eq("after_wd_quotient", last_q, 64'h0030_0000);
    check_eq("after_wd_timeout", 64'(last_to), 64'd0);

    // Divider answers in the very expiry cycle: normal result.
    stub_lat = TIMEOUT;
    push_req(32'hFFF0_0000, 32'h0020_0000, 4'd9);
    wait_idle();
    check_eq("expiry_done_timeout", 64'(last_to), 64'd0);
    check_eq("expiry_done_err", 64'(last_err), 64'd0);
    check_eq("expiry_done_quotient", last_q, 64'hFFF8_0000);

    // Reset during WAIT with two requests queued; the late div_done is ignored.
    stub_lat = 30;
    push_req(32'h0010_0000, 32'h0010_0000, 4'd10);
    push_req(32'h0020_0000, 32'h0010_0000, 4'd11);
    push_req(32'h0040_0000, 32'h0010_0000, 4'd12);
    repeat (3) sync();
    @(negedge clk);
    check_eq("pre_rst_occupancy", 64'(occupancy), 64'd2);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("wait_rst");
    check_eq("wait_rst_in_ready", 64'(in_ready), 64'd1);
    base_out = n_out;
    base_issue = n_issue;
    repeat (40) sync();
    check_eq("late_done_no_output", 64'(n_out - base_out), 64'd0);
    check_eq("late_done_no_issue", 64'(n_issue - base_issue), 64'd0);

    // Randomised traffic with random back-pressure and divider latency.
    stub_lat = 0;
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      n = $urandom;
      d = $urandom >> $urandom_range(20, 0);
      if ($urandom_range(7, 0) == 0) d = '0;
      if ($urandom_range(3, 0) == 0) sync();
      push_req(n, d, TW'(i));
    end
    wait_idle();
    ready_mode = 0;
    repeat (2) sync();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
